note_decoder: RTL and testbench
===============================

NOTE_DECODER -- requirements
Module: note_decoder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz used to derive period thresholds.
REQ-002 SHALL have parameter STABLE_COUNT, default 3, meaning the number of consecutive identical classifications required before the output changes (legal range 1..7).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port enable, input, 1, meaning run when high; when low, hold IDLE.
REQ-006 SHALL have port tone_in, input, 1, meaning an asynchronous square-wave audio tone.
REQ-007 SHALL have port note, output, 4, meaning the decoded note index 0..9, or 4'hF for no note.
REQ-008 SHALL have port note_valid, output, 1, meaning high while note is 0..9.
REQ-009 SHALL have port note_change, output, 1, meaning a one-cycle pulse whenever note changes value.
REQ-010 SHALL have port period, output, 20, meaning the last measured period in clk cycles, saturating at 20'hFFFFF.

Function
REQ-011 SHALL synchronise tone_in through two flip-flops, then detect rising edges on the synchronised signal; all periods are measured between detected edges.
REQ-012 SHALL define boundary frequencies in Hz as B0..B10 = 247, 278, 312, 340, 371, 416, 467, 509, 555, 623, 698.
REQ-013 SHALL define elaboration-time constants H_k = CLK_HZ/B_k and L_k = CLK_HZ/B_(k+1) for k=0..9, using integer division.
REQ-014 SHALL classify a measured period P as note k when L_k < P <= H_k; any other P is classified as 4'hF.
REQ-015 SHALL define P as the number of clk cycles between two consecutive edge-detect pulses.
REQ-016 SHALL implement the states IDLE, ARMED and MEASURE, with the following transitions:
- IDLE -> ARMED on the first edge.
- ARMED -> MEASURE on the next edge, which also produces the first P.
- MEASURE stays in MEASURE on each subsequent edge.
REQ-017 SHALL, on each edge that ends a period, update period to P and restart the cycle counter at 1 in that same cycle.
REQ-018 SHALL track a candidate note and a match counter:
- If the classification equals the candidate, increment the counter, saturating at STABLE_COUNT.
- Otherwise, load the classification as the new candidate and set the counter to 1.
REQ-019 SHALL, in the cycle after the match counter reaches STABLE_COUNT with a candidate different from note, load note from the candidate, set note_valid = (candidate != 4'hF), and pulse note_change for exactly one cycle.
REQ-020 SHALL declare a timeout in ARMED or MEASURE when the cycle counter reaches H_0+1 without an edge, and then:
- go to IDLE next cycle;
- clear the candidate and match counter;
- if note != 4'hF, set note = 4'hF and note_valid = 0, and pulse note_change.
REQ-021 SHALL give timeout priority over an edge arriving in the same cycle; that edge is then treated as the first edge from IDLE (next state ARMED).
REQ-022 SHALL, while enable is low, force IDLE with the same output effect as a timeout; a rising edge on enable starts from IDLE.
REQ-023 SHALL saturate the cycle counter at H_0+1 and never wrap.
REQ-024 SHALL update period with a saturating value on every ending edge, including out-of-range edges.
REQ-025 SHALL keep note_change low in every cycle in which note does not change.

Reset
REQ-026 SHALL, while reset is high at a clk edge, set the following:
- state IDLE;
- note = 4'hF, note_valid = 0, note_change = 0, period = 0;
- cycle counter, candidate and match counter cleared;
- synchroniser and edge registers cleared.
REQ-027 SHALL abandon any measurement in progress when reset is asserted mid-period; the first edge after reset release only arms the block.

Verification (CLK_HZ = 50_000_000, STABLE_COUNT = 3)
REQ-028 SHALL cover a 440 Hz tone (P = 113636): note = 5, note_valid = 1 and one note_change pulse one cycle after the 4th rising edge; period = 113636.
REQ-029 SHALL cover boundaries: P = 120192 repeated gives note 5; P = 120193 repeated gives note 4; P = 71633 repeated gives note 4'hF with note_valid = 0.
REQ-030 SHALL cover stability: a locked 262 Hz tone (P = 190839, note 0) followed by alternating 330 Hz and 392 Hz periods produces no note_change and note stays 0.
REQ-031 SHALL cover timeout: a locked note, then tone_in held low for 202430 cycles after the last edge, gives note = 4'hF, note_valid = 0 and exactly one note_change pulse.
REQ-032 SHALL cover reset and enable: reset pulsed mid-period while locked on note 7 gives all outputs at reset values next cycle and relock only after 4 further edges; enable low for one cycle gives the same result.
REQ-033 SHALL cover a note change: 440 Hz switching to 494 Hz (P = 101214) gives note 5 -> 6 after exactly 3 new periods, with a single pulse.

Source files
------------

// File: rtl/note_decoder.sv
// Square-wave tone decoder: measures the period between rising edges of tone_in and maps it
// to one of ten note bands, committing a note only after STABLE_COUNT agreeing periods.
module note_decoder #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned STABLE_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        tone_in,
    output logic [3:0]  note,
    output logic        note_valid,
    output logic        note_change,
    output logic [19:0] period
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    localparam int unsigned BOUND_HZ [0:10] = '{247, 278, 312, 340, 371, 416, 467, 509, 555, 623, 698};
    localparam logic [31:0] TIMEOUT = (CLK_HZ / BOUND_HZ[0]) + 1;
    localparam logic [2:0]  STABLE  = 3'(STABLE_COUNT);
    localparam logic [3:0]  NO_NOTE = 4'hF;

    // Note k owns the half-open band (CLK_HZ/B[k+1], CLK_HZ/B[k]].
    function automatic logic [3:0] f_classify(input logic [31:0] p);
        logic [3:0] res;
        res = NO_NOTE;
        for (int k = 0; k < 10; k++) begin
            if ((p > (CLK_HZ / BOUND_HZ[k + 1])) && (p <= (CLK_HZ / BOUND_HZ[k])))
                res = 4'(k);
        end
        return res;
    endfunction

    logic        r_sync1, r_sync2, r_prev;
    state_t      r_state;
    logic [31:0] r_cnt;
    logic [3:0]  r_cand;
    logic [2:0]  r_match;
    logic [3:0]  r_note;
    logic        r_valid;
    logic        r_change;
    logic [19:0] r_period;

    state_t      w_nx_state;
    logic [31:0] w_nx_cnt;
    logic [3:0]  w_nx_cand;
    logic [2:0]  w_nx_match;
    logic [3:0]  w_nx_note;
    logic        w_nx_valid;
    logic        w_nx_change;
    logic [19:0] w_nx_period;
    logic        w_edge;
    logic        w_abort;
    logic [3:0]  w_class;

    assign w_edge  = r_sync2 & ~r_prev;
    assign w_abort = ~enable | ((r_state != S_IDLE) && (r_cnt == TIMEOUT));
    assign w_class = f_classify(r_cnt);

    always_comb begin
        w_nx_state  = r_state;
        w_nx_cnt    = r_cnt;
        w_nx_cand   = r_cand;
        w_nx_match  = r_match;
        w_nx_note   = r_note;
        w_nx_valid  = r_valid;
        w_nx_change = 1'b0;
        w_nx_period = r_period;
        if (w_abort) begin
            w_nx_state = S_IDLE;
            w_nx_cnt   = '0;
            w_nx_cand  = NO_NOTE;
            w_nx_match = '0;
            if (r_note != NO_NOTE) begin
                w_nx_note   = NO_NOTE;
                w_nx_valid  = 1'b0;
                w_nx_change = 1'b1;
            end
            // An edge coinciding with a timeout starts a fresh measurement.
            if (enable && w_edge) begin
                w_nx_state = S_ARMED;
                w_nx_cnt   = 32'd1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        w_nx_state = S_ARMED;
                        w_nx_cnt   = 32'd1;
                    end
                end
                S_ARMED, S_MEASURE: begin
                    if (w_edge) begin
                        w_nx_state  = S_MEASURE;
                        w_nx_cnt    = 32'd1;
                        w_nx_period = (r_cnt > 32'h000F_FFFF) ? 20'hF_FFFF : r_cnt[19:0];
                        if (w_class == r_cand) begin
                            w_nx_match = (r_match < STABLE) ? r_match + 3'd1 : r_match;
                        end else begin
                            w_nx_cand  = w_class;
                            w_nx_match = 3'd1;
                        end
                    end else if (r_cnt < TIMEOUT) begin
                        w_nx_cnt = r_cnt + 32'd1;
                    end
                end
                default: begin
                    w_nx_state = S_IDLE;
                end
            endcase
            if ((r_match == STABLE) && (r_cand != r_note)) begin
                w_nx_note   = r_cand;
                w_nx_valid  = (r_cand != NO_NOTE);
                w_nx_change = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cand   <= NO_NOTE;
            r_match  <= '0;
            r_note   <= NO_NOTE;
            r_valid  <= 1'b0;
            r_change <= 1'b0;
            r_period <= '0;
        end else begin
            r_sync1  <= tone_in;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_state  <= w_nx_state;
            r_cnt    <= w_nx_cnt;
            r_cand   <= w_nx_cand;
            r_match  <= w_nx_match;
            r_note   <= w_nx_note;
            r_valid  <= w_nx_valid;
            r_change <= w_nx_change;
            r_period <= w_nx_period;
        end
    end

    assign note        = r_note;
    assign note_valid  = r_valid;
    assign note_change = r_change;
    assign period      = r_period;

endmodule

// File: tb/tb_note_decoder.sv
// Directed bench for note_decoder at CLK_HZ = 500_000 (band edges: 2024 1798 1602 1470 1347
// 1201 1070 982 900 802 716 cycles, timeout after 2025 cycles without an edge).
module tb_note_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        tone_in;
    logic [3:0]  note;
    logic        note_valid;
    logic        note_change;
    logic [19:0] period;

    int          checks  = 0;
    int          errors  = 0;
    int          chg_cnt = 0;
    logic [3:0]  last_note = 4'hF;
    logic        rst_q = 1'b1;

    note_decoder #(
        .CLK_HZ       (500_000),
        .STABLE_COUNT (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .tone_in     (tone_in),
        .note        (note),
        .note_valid  (note_valid),
        .note_change (note_change),
        .period      (period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full tone cycle, starting with its rising edge.
    task automatic pulses(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            tone_in = 1'b1;
            cycles(p / 2);
            tone_in = 1'b0;
            cycles(p - p / 2);
        end
    endtask

    always @(posedge clk) rst_q <= reset;

    // note_change must be high exactly in the cycles where note takes a new value.
    always @(negedge clk) begin
        if (!rst_q)
            check("change_iff_note_moves", 32'(note_change), 32'(note !== last_note));
        if (note_change)
            chg_cnt++;
        last_note = note;
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        tone_in = 1'b0;
        cycles(3);
        check("rst_note", 32'(note), 32'hF);
        check("rst_valid", 32'(note_valid), 32'd0);
        check("rst_change", 32'(note_change), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        reset = 1'b0;
        cycles(2);

        // 440 Hz: three periods need four rising edges.
        chg_cnt = 0;
        pulses(1136, 3);
        check("a440_two_periods_note", 32'(note), 32'hF);
        check("a440_two_periods_chg", 32'(chg_cnt), 32'd0);
        pulses(1136, 1);
        check("a440_note", 32'(note), 32'd5);
        check("a440_valid", 32'(note_valid), 32'd1);
        check("a440_chg", 32'(chg_cnt), 32'd1);
        check("a440_period", 32'(period), 32'd1136);
        pulses(1136, 2);
        check("a440_hold_note", 32'(note), 32'd5);
        check("a440_hold_chg", 32'(chg_cnt), 32'd1);

        // 440 Hz -> 494 Hz.
        chg_cnt = 0;
        pulses(1012, 3);
        check("b494_two_new_note", 32'(note), 32'd5);
        check("b494_two_new_chg", 32'(chg_cnt), 32'd0);
        pulses(1012, 1);
        check("b494_note", 32'(note), 32'd6);
        check("b494_chg", 32'(chg_cnt), 32'd1);
        check("b494_period", 32'(period), 32'd1012);

        // Timeout: tone held low, last rising edge 1012 cycles ago.
        chg_cnt = 0;
        cycles(2020 - 1012);
        check("tmo_before_note", 32'(note), 32'd6);
        cycles(20);
        check("tmo_note", 32'(note), 32'hF);
        check("tmo_valid", 32'(note_valid), 32'd0);
        check("tmo_chg", 32'(chg_cnt), 32'd1);
        check("tmo_period", 32'(period), 32'd1012);

        // Band boundaries.
        pulses(1201, 4);
        check("bnd_1201_note", 32'(note), 32'd5);
        check("bnd_1201_period", 32'(period), 32'd1201);
        pulses(1202, 4);
        check("bnd_1202_note", 32'(note), 32'd4);
        pulses(716, 4);
        check("bnd_716_note", 32'(note), 32'hF);
        check("bnd_716_valid", 32'(note_valid), 32'd0);
        pulses(2024, 4);
        check("bnd_2024_note", 32'(note), 32'd0);
        check("bnd_2024_valid", 32'(note_valid), 32'd1);
        check("bnd_2024_period", 32'(period), 32'd2024);

        // Stability: alternating 330 Hz / 392 Hz never agree three times.
        chg_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            pulses(1515, 1);
            pulses(1275, 1);
        end
        check("alt_note", 32'(note), 32'd0);
        check("alt_chg", 32'(chg_cnt), 32'd0);
        check("alt_period", 32'(period), 32'd1515);

        // Reset mid-period while locked on note 7.
        pulses(940, 4);
        check("n7_note", 32'(note), 32'd7);
        tone_in = 1'b1;
        cycles(300);
        tone_in = 1'b0;
        cycles(100);
        reset = 1'b1;
        cycles(1);
        check("mid_rst_note", 32'(note), 32'hF);
        check("mid_rst_valid", 32'(note_valid), 32'd0);
        check("mid_rst_change", 32'(note_change), 32'd0);
        check("mid_rst_period", 32'(period), 32'd0);
        reset   = 1'b0;
        chg_cnt = 0;
        pulses(940, 3);
        check("rst_relock_early", 32'(note), 32'hF);
        pulses(940, 1);
        check("rst_relock_note", 32'(note), 32'd7);
        check("rst_relock_chg", 32'(chg_cnt), 32'd1);

        // Enable low for one cycle mid-period.
        tone_in = 1'b1;
        cycles(300);
        tone_in = 1'b0;
        cycles(100);
        chg_cnt = 0;
        enable  = 1'b0;
        cycles(1);
        check("en_off_note", 32'(note), 32'hF);
        check("en_off_valid", 32'(note_valid), 32'd0);
        check("en_off_change", 32'(note_change), 32'd1);
        check("en_off_period", 32'(period), 32'd940);
        enable = 1'b1;
        pulses(940, 3);
        check("en_relock_early", 32'(note), 32'hF);
        pulses(940, 1);
        check("en_relock_note", 32'(note), 32'd7);
        check("en_relock_chg", 32'(chg_cnt), 32'd2);

        cycles(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
